alu_issue_unit: RTL

- Registered command front-end for the combinational `ale` ALU.
- Accepts operand/opcode requests over a valid/ready interface and drives `ale`'s a, b and alu_select.
- Captures the result and returns it over a valid/ready response interface.
- Also provides a self-timed sweep mode that steps through every defined opcode on one operand pair, for bring-up and on-chip checking of the ALU.

---
 rtl/alu_issue_pkg.sv | 35 +++
 rtl/alu_issue_unit_if.sv | 35 +++
 rtl/alu_resp_reg.sv | 45 ++++
 rtl/alu_issue_unit.sv | 110 +++++++++++
 4 files changed

// File: rtl/alu_issue_pkg.sv
// Shared types for the ALU issue unit: opcode map, FSM states and the
// opcode legality helper.
package alu_issue_pkg;

  typedef enum logic [3:0] {
    OP_MOV = 4'd0,
    OP_ADD = 4'd1,
    OP_SUB = 4'd2,
    OP_MUL = 4'd3,
    OP_DIV = 4'd4,
    OP_XOR = 4'd5,
    OP_AND = 4'd6,
    OP_NOT = 4'd7,
    OP_SHL = 4'd8,
    OP_SHR = 4'd9
  } alu_op_t;

  localparam logic [3:0] OP_LAST = 4'(OP_SHR);

  typedef enum logic [2:0] {
    IDLE,
    EXEC,
    CAPTURE,
    HOLD,
    SWEEP_EXEC,
    SWEEP_CAPTURE,
    SWEEP_HOLD
  } state_t;

  // Codes above OP_LAST have no ALU function behind them.
  function automatic logic is_legal_op(input logic [3:0] op);
    return op <= OP_LAST;
  endfunction

endpackage

// File: rtl/alu_issue_unit_if.sv
// Request/response handshake bundle of the ALU issue unit.
// resp_err exists only when ALU_ISSUE_ERR_EN is defined.
interface alu_issue_unit_if #(
  parameter int N = 4
);
  logic         req_valid;
  logic         req_ready;
  logic [N-1:0] req_a;
  logic [N-1:0] req_b;
  logic [3:0]   req_op;
  logic         resp_valid;
  logic         resp_ready;
  logic [N-1:0] resp_result;
  logic [3:0]   resp_op;
`ifdef ALU_ISSUE_ERR_EN
  logic         resp_err;
`endif

  modport master (
    output req_valid, req_a, req_b, req_op, resp_ready,
    input  req_ready, resp_valid, resp_result, resp_op
`ifdef ALU_ISSUE_ERR_EN
    , input resp_err
`endif
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, resp_ready,
    output req_ready, resp_valid, resp_result, resp_op
`ifdef ALU_ISSUE_ERR_EN
    , output resp_err
`endif
  );

endinterface

// File: rtl/alu_resp_reg.sv
// Response holding register: loads on strobe, holds until valid/ready
// handshake. Error flag present only with ALU_ISSUE_ERR_EN.
module alu_resp_reg #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [N-1:0] load_result,
  input  logic [3:0]   load_op,
`ifdef ALU_ISSUE_ERR_EN
  input  logic         load_err,
  output logic         err,
`endif
  input  logic         ready,
  output logic         valid,
  output logic [N-1:0] result,
  output logic [3:0]   op
);

  // Capture on load; drop valid (and error) once the consumer takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid  <= 1'b0;
      result <= '0;
      op     <= '0;
`ifdef ALU_ISSUE_ERR_EN
      err    <= 1'b0;
`endif
    end else if (load) begin
      valid  <= 1'b1;
      result <= load_result;
      op     <= load_op;
`ifdef ALU_ISSUE_ERR_EN
      err    <= load_err;
`endif
    end else if (valid && ready) begin
      valid  <= 1'b0;
`ifdef ALU_ISSUE_ERR_EN
      err    <= 1'b0;
`endif
    end
  end

endmodule

// File: rtl/alu_issue_unit.sv
// Registered command front-end for the combinational ale ALU, with a
// self-timed sweep over every defined opcode. Optional macro
// ALU_ISSUE_ERR_EN adds resp_err flagging of illegal opcodes.
module alu_issue_unit
  import alu_issue_pkg::*;
#(
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           sweep_start,
  output logic           busy,
  output logic [N-1:0]   alu_a,
  output logic [N-1:0]   alu_b,
  output logic [3:0]     alu_select,
  input  logic [N-1:0]   alu_result,
  alu_issue_unit_if.slave bus
);

  state_t       state_q;
  state_t       state_d;
  logic         sweep_go;
  logic         accept;
  logic         hs;
  logic         load;
  logic         last_op;
  logic         op_legal;
  logic [N-1:0] cap_result;

  // Sweep has priority over a simultaneous request.
  assign bus.req_ready = (state_q == IDLE) && !sweep_start;
  assign sweep_go      = (state_q == IDLE) && sweep_start;
  assign accept        = bus.req_valid && bus.req_ready;
  assign hs            = bus.resp_valid && bus.resp_ready;
  assign last_op       = (alu_select == OP_LAST);
  assign op_legal      = is_legal_op(alu_select);
  assign cap_result    = op_legal ? alu_result : '0;

  // Next-state and load strobe for the response register.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        if (sweep_go)    state_d = SWEEP_EXEC;
        else if (accept) state_d = EXEC;
      end
      EXEC:          state_d = CAPTURE;
      CAPTURE: begin
        load    = 1'b1;
        state_d = HOLD;
      end
      HOLD:          if (hs) state_d = IDLE;
      SWEEP_EXEC:    state_d = SWEEP_CAPTURE;
      SWEEP_CAPTURE: begin
        load    = 1'b1;
        state_d = SWEEP_HOLD;
      end
      SWEEP_HOLD:    if (hs) state_d = last_op ? IDLE : SWEEP_EXEC;
      default:       state_d = IDLE;
    endcase
  end

  // FSM state register; busy registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      busy    <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != IDLE);
    end
  end

  // ALU operand/opcode drive, held stable from issue until handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a      <= '0;
      alu_b      <= '0;
      alu_select <= '0;
    end else if (sweep_go) begin
      alu_a      <= bus.req_a;
      alu_b      <= bus.req_b;
      alu_select <= '0;
    end else if (accept) begin
      alu_a      <= bus.req_a;
      alu_b      <= bus.req_b;
      alu_select <= bus.req_op;
    end else if ((state_q == SWEEP_HOLD) && hs && !last_op) begin
      alu_select <= 4'(alu_select + 4'd1);
    end
  end

  alu_resp_reg #(.N(N)) u_resp (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .load_result (cap_result),
    .load_op     (alu_select),
`ifdef ALU_ISSUE_ERR_EN
    .load_err    ((state_q == CAPTURE) && !op_legal),
    .err         (bus.resp_err),
`endif
    .ready       (bus.resp_ready),
    .valid       (bus.resp_valid),
    .result      (bus.resp_result),
    .op          (bus.resp_op)
  );

endmodule
